// File: rtl/uart_tx_arb.sv
// uart_tx_arb: shares one uart_tx byte transmitter between N_REQ requesters.
//
// A requester that wins arbitration owns the transmitter for a whole frame,
// from its first byte until the byte flagged last is accepted. Winners are
// picked round-robin, starting from the requester after the previous owner.
// Accepted bytes go into a one-byte output register that feeds uart_tx.
// An owner that stops presenting bytes for IDLE_TIMEOUT cycles loses the
// grant, so a stalled peripheral cannot hang the UART.
//
// Ports:
//   clk_i        system clock
//   rst_ni       asynchronous active-low reset
//   req_data_i   requester bytes, requester k on bits [k*DW +: DW]
//   req_valid_i  per-requester byte valid
//   req_last_i   per-requester last byte of frame (qualified by valid)
//   req_ready_o  per-requester byte accepted when valid & ready
//   tx_data_o    byte to uart_tx
//   tx_valid_o   byte valid to uart_tx
//   tx_ready_i   uart_tx can take a byte
//   grant_o      one-hot current owner, zero when idle
//   busy_o       frame locked or a byte still waiting in the output register
//   timeout_o    one-cycle pulse in the cycle a grant is force-released
module uart_tx_arb #(
  parameter int N_REQ        = 4,
  parameter int DW           = 8,
  parameter int IDLE_TIMEOUT = 1024
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [N_REQ*DW-1:0] req_data_i,
  input  logic [N_REQ-1:0]    req_valid_i,
  input  logic [N_REQ-1:0]    req_last_i,
  output logic [N_REQ-1:0]    req_ready_o,
  output logic [DW-1:0]       tx_data_o,
  output logic                tx_valid_o,
  input  logic                tx_ready_i,
  output logic [N_REQ-1:0]    grant_o,
  output logic                busy_o,
  output logic                timeout_o
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_LIMIT = CW'(IDLE_TIMEOUT);
  localparam logic [IW-1:0] LAST_IDX = IW'(N_REQ - 1);
  localparam logic [IW:0]   N_WIDE   = (IW + 1)'(N_REQ);

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e            state_q, state_d;
  logic [N_REQ-1:0]  grant_q, grant_d;
  logic [IW-1:0]     owner_q, owner_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [CW-1:0]     idle_cnt_q, idle_cnt_d;
  logic [DW-1:0]     tx_data_q, tx_data_d;
  logic              tx_valid_q, tx_valid_d;

  logic [IW:0]       cand;
  logic [IW-1:0]     sel_idx;
  logic              sel_found;
  logic [IW-1:0]     next_owner;
  logic [DW-1:0]     owner_data;
  logic              owner_valid;
  logic              owner_last;
  logic              slot_free;
  logic              accept;
  logic              timeout;

  assign owner_data  = req_data_i[owner_q*DW +: DW];
  assign owner_valid = req_valid_i[owner_q];
  assign owner_last  = req_last_i[owner_q];
  assign next_owner  = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;

  // The output register can take a new byte when empty or draining this cycle.
  assign slot_free   = !tx_valid_q || tx_ready_i;
  assign accept      = (state_q == LOCKED) && owner_valid && slot_free;
  assign timeout     = (IDLE_TIMEOUT > 0) && (state_q == LOCKED) &&
                       (idle_cnt_q == TO_LIMIT);

  // Round-robin search: first valid requester at ptr, ptr+1, ... wrapping.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = {1'b0, ptr_q} + (IW + 1)'(i);
      if (cand >= N_WIDE) cand = cand - N_WIDE;
      if (!sel_found && req_valid_i[cand[IW-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = cand[IW-1:0];
      end
    end
  end

  // Only the owner ever sees ready; everyone else is held off.
  always_comb begin
    req_ready_o = '0;
    if (state_q == LOCKED) req_ready_o[owner_q] = slot_free;
  end

  // Next-state, grant, pointer, idle counter and output register.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    owner_d    = owner_q;
    ptr_d      = ptr_q;
    idle_cnt_d = idle_cnt_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;

    // Drain and accept in the same cycle leaves the register full with the new byte.
    if (tx_valid_q && tx_ready_i) tx_valid_d = 1'b0;
    if (accept) begin
      tx_valid_d = 1'b1;
      tx_data_d  = owner_data;
    end

    case (state_q)
      IDLE: begin
        idle_cnt_d = '0;
        if (sel_found) begin
          state_d = LOCKED;
          owner_d = sel_idx;
          grant_d = N_REQ'(1) << sel_idx;
        end
      end
      LOCKED: begin
        // A byte still in the output register keeps draining after release.
        if (timeout || (accept && owner_last)) begin
          state_d    = IDLE;
          grant_d    = '0;
          ptr_d      = next_owner;
          idle_cnt_d = '0;
        end else if (owner_valid) begin
          idle_cnt_d = '0;
        end else if (IDLE_TIMEOUT > 0) begin
          idle_cnt_d = idle_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset drops any byte sitting in the output register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      owner_q    <= '0;
      ptr_q      <= '0;
      idle_cnt_q <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      owner_q    <= owner_d;
      ptr_q      <= ptr_d;
      idle_cnt_q <= idle_cnt_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
    end
  end

  assign grant_o    = grant_q;
  assign tx_valid_o = tx_valid_q;
  assign tx_data_o  = tx_data_q;
  assign busy_o     = (state_q == LOCKED) || tx_valid_q;
  assign timeout_o  = timeout;

endmodule

// File: tb/tb_uart_tx_arb.sv
// tb_uart_tx_arb: directed self-checking bench for uart_tx_arb with four
// requesters, 8-bit bytes and a 16-cycle idle timeout. A sink records every
// byte handed to uart_tx and a monitor records grant patterns.
module tb_uart_tx_arb;

  logic        clk;
  logic        rst_n;
  logic [31:0] req_data;
  logic [3:0]  req_valid;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [3:0]  grant;
  logic        busy;
  logic        timeout;

  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  logic [7:0]  sent_q[$];
  logic [3:0]  grant_seq[$];
  logic        rec_grant = 1'b0;
  logic        watch_g1 = 1'b0;
  logic        seen_g1 = 1'b0;
  int          c_last;
  int          c_first;
  int          c_dummy;

  uart_tx_arb #(.N_REQ(4), .DW(8), .IDLE_TIMEOUT(16)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_data_i  (req_data),
    .req_valid_i (req_valid),
    .req_last_i  (req_last),
    .req_ready_o (req_ready),
    .tx_data_o   (tx_data),
    .tx_valid_o  (tx_valid),
    .tx_ready_i  (tx_ready),
    .grant_o     (grant),
    .busy_o      (busy),
    .timeout_o   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Inputs only change just after a rising edge, so the negedge view matches the next edge.
  always @(negedge clk) begin
    if (rst_n && tx_valid && tx_ready) sent_q.push_back(tx_data);
    if (rec_grant && grant != 4'b0) grant_seq.push_back(grant);
    if (watch_g1 && grant[1]) seen_g1 = 1'b1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_sent(input string tag, input int idx, input logic [7:0] exp);
    logic [31:0] obs;
    obs = (idx < sent_q.size()) ? {24'd0, sent_q[idx]} : 32'hDEAD_BEEF;
    check_output(tag, obs, {24'd0, exp});
  endtask

  // Present one byte from requester k and wait (bounded) until it is accepted.
  task automatic apply_stimulus(input int k, input logic [7:0] d, input logic l, output int acc_cyc);
    logic done;
    done = 1'b0;
    acc_cyc = -1;
    req_data[k*8 +: 8] = d;
    req_valid[k] = 1'b1;
    req_last[k] = l;
    #1;
    for (int n = 0; n < 200 && !done; n++) begin
      if (req_ready[k]) begin
        done = 1'b1;
        tick();
        acc_cyc = cyc;
      end else begin
        tick();
      end
    end
    check_output("accept_bound", {31'd0, done}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    req_data = '0;
    req_valid = '0;
    req_last = '0;
    tx_ready = 1'b1;
    #2;
    check_output("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    check_output("rst_tx_data", {24'd0, tx_data}, 32'd0);
    check_output("rst_grant", {28'd0, grant}, 32'd0);
    check_output("rst_ready", {28'd0, req_ready}, 32'd0);
    check_output("rst_busy", {31'd0, busy}, 32'd0);
    check_output("rst_timeout", {31'd0, timeout}, 32'd0);
    #1;
    rst_n = 1'b1;
    tick();

    // Single-byte frame from requester 2.
    req_data[23:16] = 8'h55;
    req_valid = 4'b0100;
    req_last = 4'b0100;
    #1;
    check_output("t1_idle_ready", {28'd0, req_ready}, 32'd0);
    tick();
    check_output("t1_grant", {28'd0, grant}, 32'h4);
    check_output("t1_ready", {28'd0, req_ready}, 32'h4);
    check_output("t1_txv_c1", {31'd0, tx_valid}, 32'd0);
    tick();
    check_output("t1_txv_c2", {31'd0, tx_valid}, 32'd1);
    check_output("t1_txd", {24'd0, tx_data}, 32'h55);
    check_output("t1_grant_rel", {28'd0, grant}, 32'd0);
    check_output("t1_busy", {31'd0, busy}, 32'd1);
    req_valid = '0;
    req_last = '0;
    tick();
    check_output("t1_drained", {31'd0, tx_valid}, 32'd0);
    check_output("t1_idle_busy", {31'd0, busy}, 32'd0);
    check_sent("t1_byte", 0, 8'h55);

    // Three-byte frame from requester 0 while requester 1 waits.
    sent_q.delete();
    req_data[15:8] = 8'h11;
    req_valid[1] = 1'b1;
    req_last[1] = 1'b1;
    watch_g1 = 1'b1;
    apply_stimulus(0, 8'hAA, 1'b0, c_dummy);
    apply_stimulus(0, 8'h00, 1'b0, c_dummy);
    apply_stimulus(0, 8'hFF, 1'b1, c_last);
    req_valid[0] = 1'b0;
    req_last[0] = 1'b0;
    watch_g1 = 1'b0;
    check_output("t2_no_g1_midframe", {31'd0, seen_g1}, 32'd0);
    apply_stimulus(1, 8'h11, 1'b1, c_first);
    req_valid = '0;
    req_last = '0;
    check_output("t2_handover_gap", c_first - c_last, 32'd2);
    tick();
    tick();
    check_output("t2_count", sent_q.size(), 32'd4);
    check_sent("t2_b0", 0, 8'hAA);
    check_sent("t2_b1", 1, 8'h00);
    check_sent("t2_b2", 2, 8'hFF);
    check_sent("t2_b3", 3, 8'h11);

    // Fresh reset so the pointer starts at 0, then everyone requests forever.
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    sent_q.delete();
    grant_seq.delete();
    req_data = 32'h13121110;
    req_valid = 4'b1111;
    req_last = 4'b1111;
    rec_grant = 1'b1;
    repeat (10) tick();
    req_valid = '0;
    req_last = '0;
    rec_grant = 1'b0;
    tick();
    tick();
    check_output("t3_grants", grant_seq.size(), 32'd5);
    for (int i = 0; i < 5; i++) begin
      logic [3:0] exp_g;
      exp_g = 4'b0001 << (i % 4);
      check_output("t3_grant_seq", (i < grant_seq.size()) ? {28'd0, grant_seq[i]} : 32'hDEAD_BEEF,
                   {28'd0, exp_g});
      check_sent("t3_byte_seq", i, 8'h10 + 8'(i % 4));
    end

    // Stalled uart_tx: output register must hold, owner must see not-ready.
    sent_q.delete();
    tx_ready = 1'b0;
    apply_stimulus(1, 8'h5A, 1'b0, c_dummy);
    req_data[15:8] = 8'h6B;
    #1;
    for (int i = 0; i < 50; i++) begin
      check_output("t4_stall_data", {24'd0, tx_data}, 32'h5A);
      check_output("t4_stall_ready", {28'd0, req_ready}, 32'd0);
      tick();
    end
    tx_ready = 1'b1;
    #1;
    check_output("t4_ready_back", {28'd0, req_ready}, 32'h2);
    tick();
    check_output("t4_b2b_valid", {31'd0, tx_valid}, 32'd1);
    check_output("t4_b2b_data", {24'd0, tx_data}, 32'h6B);
    apply_stimulus(1, 8'h7C, 1'b1, c_dummy);
    req_valid = '0;
    req_last = '0;
    tick();
    tick();
    check_output("t4_count", sent_q.size(), 32'd3);
    check_sent("t4_b0", 0, 8'h5A);
    check_sent("t4_b1", 1, 8'h6B);
    check_sent("t4_b2", 2, 8'h7C);

    // Owner 3 goes silent mid-frame and is force-released.
    sent_q.delete();
    tx_ready = 1'b0;
    apply_stimulus(3, 8'h42, 1'b0, c_dummy);
    req_valid[3] = 1'b0;
    req_data[7:0] = 8'h99;
    req_data[23:16] = 8'h22;
    req_valid[0] = 1'b1;
    req_last[0] = 1'b1;
    req_valid[2] = 1'b1;
    req_last[2] = 1'b1;
    #1;
    check_output("t5_nonowner_ready", {28'd0, req_ready}, 32'd0);
    check_output("t5_grant3", {28'd0, grant}, 32'h8);
    repeat (15) tick();
    check_output("t5_no_timeout_15", {31'd0, timeout}, 32'd0);
    check_output("t5_grant_15", {28'd0, grant}, 32'h8);
    tick();
    check_output("t5_timeout_16", {31'd0, timeout}, 32'd1);
    check_output("t5_txv_held", {31'd0, tx_valid}, 32'd1);
    tick();
    check_output("t5_timeout_pulse_end", {31'd0, timeout}, 32'd0);
    check_output("t5_grant_released", {28'd0, grant}, 32'd0);
    check_output("t5_busy_draining", {31'd0, busy}, 32'd1);
    tick();
    check_output("t5_next_grant", {28'd0, grant}, 32'h1);
    check_output("t5_old_byte", {24'd0, tx_data}, 32'h42);
    tx_ready = 1'b1;
    #1;
    check_output("t5_ready0", {28'd0, req_ready}, 32'h1);
    tick();
    check_output("t5_new_valid", {31'd0, tx_valid}, 32'd1);
    check_output("t5_new_data", {24'd0, tx_data}, 32'h99);
    req_valid = '0;
    req_last = '0;
    tick();
    tick();
    check_output("t5_count", sent_q.size(), 32'd2);
    check_sent("t5_b0", 0, 8'h42);
    check_sent("t5_b1", 1, 8'h99);

    // Reset in the middle of a frame with a byte waiting in the register.
    sent_q.delete();
    tx_ready = 1'b0;
    apply_stimulus(1, 8'h31, 1'b0, c_dummy);
    check_output("t6_pre_txv", {31'd0, tx_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_output("t6_rst_txv", {31'd0, tx_valid}, 32'd0);
    check_output("t6_rst_txd", {24'd0, tx_data}, 32'd0);
    check_output("t6_rst_grant", {28'd0, grant}, 32'd0);
    check_output("t6_rst_ready", {28'd0, req_ready}, 32'd0);
    check_output("t6_rst_busy", {31'd0, busy}, 32'd0);
    req_valid = '0;
    req_last = '0;
    rst_n = 1'b1;
    tx_ready = 1'b1;
    req_data[15:8] = 8'h77;
    req_valid[1] = 1'b1;
    req_last[1] = 1'b1;
    tick();
    check_output("t6_grant", {28'd0, grant}, 32'h2);
    tick();
    req_valid = '0;
    req_last = '0;
    check_output("t6_txd", {24'd0, tx_data}, 32'h77);
    tick();
    tick();
    check_output("t6_count", sent_q.size(), 32'd1);
    check_sent("t6_b0", 0, 8'h77);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
